// File: rtl/sdes_iter_ctrl_if.sv
// sdes_iter_ctrl_if: request/completion bundle between a byte-stream requester and sdes_iter_ctrl
//   master (requester) drives start, mode, key[0:9], data_in[0:7]
//   slave (controller) drives ready, busy, done, data_out[0:7]
//   bit 0 is the MSB on every bus
interface sdes_iter_ctrl_if;
   logic       start;
   logic       mode;
   logic [0:9] key;
   logic [0:7] data_in;
   logic       ready;
   logic       busy;
   logic       done;
   logic [0:7] data_out;
   modport master (output start, mode, key, data_in, input ready, busy, done, data_out);
   modport slave (input start, mode, key, data_in, output ready, busy, done, data_out);
endinterface

// File: rtl/sdes_iter_ctrl.sv
// sdes_iter_ctrl: iterative S-DES encrypt/decrypt controller sharing one fk across both rounds
//   clk, rst        : clock, synchronous active-high reset
//   io.start        : request, sampled only in IDLE together with mode/key/data_in
//   io.mode         : 0 = encrypt (K1 then K2), 1 = decrypt (K2 then K1)
//   io.key/data_in  : 10-bit key, 8-bit input block
//   io.ready/busy   : IDLE / not IDLE
//   io.done         : one-cycle pulse on the edge that updates io.data_out
module sdes_iter_ctrl #(
   parameter bit SKIP_KEYGEN = 1'b1
) (
   input logic             clk,
   input logic             rst,
   sdes_iter_ctrl_if.slave io
);
   typedef enum logic [2:0] {IDLE, KEY, R1, R2, OUT} state_t;
   // S-boxes indexed by {row, col}
   localparam logic [1:0] S0 [0:15] = '{2'd1, 2'd0, 2'd3, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0,
                                        2'd0, 2'd2, 2'd1, 2'd3, 2'd3, 2'd1, 2'd3, 2'd2};
   localparam logic [1:0] S1 [0:15] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd0, 2'd1, 2'd3,
                                        2'd3, 2'd0, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd3};
   state_t     st;
   logic       mode_r, cache_valid, done_r;
   logic [0:9] key_r, cached_key, p;
   logic [0:7] data_r, k1, k2, rnd, dout_r, ip, fk_in, fk_sk, fk_out;

   function automatic logic [0:7] p8(input logic [0:9] s);
      return {s[5], s[2], s[6], s[3], s[7], s[4], s[9], s[8]};
   endfunction

   function automatic logic [0:7] ipinv(input logic [0:7] x);
      return {x[3], x[0], x[2], x[4], x[6], x[1], x[7], x[5]};
   endfunction

   function automatic logic [0:7] fk(input logic [0:7] d, input logic [0:7] sk);
      logic [0:7] x;
      logic [0:3] y;
      x = {d[7], d[4], d[5], d[6], d[5], d[6], d[7], d[4]} ^ sk;
      y = {S0[{x[0], x[3], x[1], x[2]}], S1[{x[4], x[7], x[5], x[6]}]};
      return {d[0:3] ^ {y[1], y[3], y[2], y[0]}, d[4:7]};
   endfunction

   assign p      = {key_r[2], key_r[4], key_r[1], key_r[6], key_r[3],
                    key_r[9], key_r[0], key_r[8], key_r[7], key_r[5]};
   assign ip     = {data_r[1], data_r[5], data_r[2], data_r[0], data_r[3], data_r[7], data_r[4], data_r[6]};
   // R1 takes IP(data); R2 takes SW(round); K1 goes to R1 in encrypt and to R2 in decrypt
   assign fk_in  = st == R1 ? ip : {rnd[4:7], rnd[0:3]};
   assign fk_sk  = ((st == R1) ^ mode_r) ? k1 : k2;
   assign fk_out = fk(fk_in, fk_sk);

   assign io.ready    = st == IDLE;
   assign io.busy     = st != IDLE;
   assign io.done     = done_r;
   assign io.data_out = dout_r;

   // data_out/done are loaded on the R2->OUT edge so done is high during OUT
   always_ff @(posedge clk)
      if (rst) begin
         st          <= IDLE;
         mode_r      <= 1'b0;
         key_r       <= '0;
         data_r      <= '0;
         k1          <= '0;
         k2          <= '0;
         cached_key  <= '0;
         cache_valid <= 1'b0;
         rnd         <= '0;
         dout_r      <= '0;
         done_r      <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (st)
            IDLE: if (io.start) begin
               mode_r <= io.mode;
               key_r  <= io.key;
               data_r <= io.data_in;
               st     <= (SKIP_KEYGEN && cache_valid && io.key == cached_key) ? R1 : KEY;
            end
            KEY: begin
               k1          <= p8({p[1:4], p[0], p[6:9], p[5]});
               k2          <= p8({p[3:4], p[0:2], p[8:9], p[5:7]});
               cached_key  <= key_r;
               cache_valid <= 1'b1;
               st          <= R1;
            end
            R1: begin
               rnd <= fk_out;
               st  <= R2;
            end
            R2: begin
               rnd    <= fk_out;
               dout_r <= ipinv(fk_out);
               done_r <= 1'b1;
               st     <= OUT;
            end
            default: st <= IDLE;
         endcase
      end
endmodule

// File: doc/sdes_iter_ctrl.md
Name: sdes_iter_ctrl

Overview:
- Iterative S-DES encrypt/decrypt controller.
- Shares a single fk instance across both Feistel rounds, so the datapath needs only one fk.
- Expands the 10-bit key into subkeys, sequences IP -> fk -> SW -> fk -> IPinv over successive clocks, and reports completion with a start/done handshake.
- Sits between a byte-stream requester and the existing IP, fk, SW and IPinv datapath blocks.

Parameters:
- SKIP_KEYGEN, 1: when 1, the KEY state is bypassed if the key matches the cached key of the previous operation. When 0, KEY always runs.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request pulse; sampled only in IDLE
- mode  input  1  0 = encrypt (subkeys K1 then K2), 1 = decrypt (K2 then K1)
- key  input  [0:9]  10-bit S-DES key; bit 0 is key bit 1 (MSB)
- data_in  input  [0:7]  plaintext or ciphertext; bit 0 is MSB
- ready  output  1  high only in IDLE
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse when data_out is updated
- data_out  output  [0:7]  result, held until the next completion

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-high. Ports clk, rst.
- Reset values on rst at posedge, regardless of state:
  - state = IDLE, data_out = 8'h00, done = 0, busy = 0, ready = 1
  - cache_valid = 0, internal subkey and round registers = 0
  - An in-flight operation is abandoned with no done pulse.
- FSM states: IDLE, KEY, R1, R2, OUT.
- IDLE:
  - If start = 1, latch mode, key and data_in into internal registers.
  - Go to R1 if SKIP_KEYGEN = 1 and cache_valid = 1 and key == cached_key.
  - Otherwise go to KEY.
  - If start = 0, stay in IDLE.
- KEY (1 cycle):
  - p = P10(key) using table 3 5 2 7 4 10 1 9 8 6 (1-indexed source bits).
  - K1 = P8(LS1 on each 5-bit half of p).
  - K2 = P8(LS2 applied after LS1, i.e. cumulative shift of 3).
  - P8 table: 6 3 7 4 8 5 10 9.
  - Register K1, K2 and cached_key; set cache_valid = 1; go to R1.
- R1 (1 cycle): round register <= fk(IP(data_reg), first subkey). First subkey is K1 in encrypt mode, K2 in decrypt mode. Go to R2.
- R2 (1 cycle): round register <= fk(SW(round register), second subkey). Go to OUT.
- OUT (1 cycle): data_out <= IPinv(round register); done = 1 for this cycle only; go to IDLE.
- Single fk instance: its input mux and subkey mux are selected by state (R1 or R2). Its output is don't-care in other states.
- Latency, counted from the start-sampled edge to the cycle in which done is high:
  - 4 cycles with KEY (IDLE -> KEY -> R1 -> R2 -> OUT).
  - 3 cycles when KEY is skipped.
- Handshake:
  - start is ignored while busy, including the OUT/done cycle; the requester must re-assert it once ready = 1.
  - Latched inputs are immune to changes on key, data_in or mode after the start edge.
- Output timing: done and data_out are registered. data_out changes only on the edge that raises done.
- Key cache: a mode change alone does not invalidate the cache, since subkeys are mode-independent. rst clears the cache.
- Bit numbering is [0:N] with index 0 as MSB on every bus, matching the existing datapath blocks.

Test Plan:
- Encrypt, first use: rst, then start with mode = 0, key = 1010000010, data_in = 10010111.
  - Internal K1 = 10100100, K2 = 01000011.
  - done is high exactly 4 cycles after the start edge, with data_out = 00111000.
- Decrypt, cached key: on the cycle after the previous test's done, start with mode = 1, same key, data_in = 00111000.
  - KEY is skipped; done comes 3 cycles later with data_out = 10010111.
- Parameter check: SKIP_KEYGEN = 0, repeat the decrypt test -> latency is 4 cycles; result is unchanged.
- Start while busy: assert start every cycle of an operation, and change data_in to 11111111 in cycle 1.
  - Result still matches the originally latched data.
  - Exactly one done pulse.
  - Next operation begins only after ready returns high.
- Reset mid-operation: assert rst during R1.
  - Next edge: state IDLE, busy = 0, data_out = 00000000, no done pulse.
  - The following start with the same key goes through KEY (cache invalidated), latency 4.
- Key change: after an operation with key 1010000010, start with key 0000000000 and data_in = 00000000.
  - KEY state is entered (latency 4).
  - data_out matches the golden S-DES software model.
